processor_z: RTL and testbench
==============================

Name: processor_z

Overview:
processor_z is a small 32-bit, 4-stage in-order pipelined processor: Fetch, Decode, Execute, Write-back.
- Program load: a host writes the program into an internal 512x32 instruction RAM while working=0.
- Run: once working=1, the core executes IRMOV, ADD, SUB, AND and XOR on eight 32-bit registers.
- Observation: every register is exposed directly, plus one selectable through rID. It is the top of the Processor-Z datapath.

Parameters:
ADDR_W, 9, instruction RAM address width (512 words)
DATA_W, 32, data, register and instruction width
NREG, 8, number of architectural registers

Ports:
clock  input  1  single system clock, rising-edge
reset  input  1  synchronous, active-high
addr  input  9  host RAM write address (used when working=0)
wr  input  1  host RAM write enable
wdata  input  32  host RAM write data
working  input  1  1 = run the program; 0 = load mode, core idle
rID  input  4  register select for rdata
valE  output  32  ALU result of the instruction currently in Execute
r0..r7  output  32 each  architectural register contents
rdata  output  32  register selected by rID

Behaviour:
- Instruction fields: [31:28] icode, [27:24] ifun, [23:20] rA, [19:16] rB, [15:0] valC.
- Opcodes ({icode,ifun}):
  - 0x10 IRMOV: R[rB] <= zero-extended valC; rA is unused (0xF by convention).
  - 0x20 ADD: R[rA] <= R[rA] + R[rB].
  - 0x21 SUB: R[rA] <= R[rA] - R[rB].
  - 0x22 AND: R[rA] <= R[rA] & R[rB].
  - 0x23 XOR: R[rA] <= R[rA] ^ R[rB].
  - Any other encoding, including 0x00000000, is a NOP.
- Arithmetic is 32-bit modulo; no flags.
- A destination index of 8..15 suppresses the write. A source index of 8..15 reads 0.
- ALU alufun encoding: 0 add, 1 sub (A-B), 2 and, 3 xor. A = R[rA], B = R[rB].
- RAM:
  - Synchronous.
  - A write occurs at a rising edge when wr=1 and working=0.
  - wr is ignored while working=1.
  - Read data is registered, giving 1-cycle read latency.
  - Contents are not affected by reset.
- Fetch: while working=1, the RAM address is PC and PC increments each cycle, wrapping 511->0. While working=0, PC holds and NOPs enter Decode.
- Pipeline timing: an instruction fetched at edge N is in Decode after N+1, its result is latched in Execute after N+2, and it is written to the register file at N+3.
- Hazards:
  - Operands are forwarded from the Execute result and from the Write-back value.
  - The register file is write-through: a read during a write returns the new value.
  - Any instruction therefore sees the results of all earlier instructions, with no stalls and no bubbles.
  - If two older instructions write the same register, the younger one wins.
- valE: combinational ALU output for the instruction in Execute; 0 when that instruction is not an ALU op.
- rdata = R[rID] for rID 0..7, 0 for rID 8..15. It is combinational.
- Reset:
  - Clears R0..R7 to 0 and PC to 0.
  - All pipeline registers become NOP with writes disabled; valE becomes 0.
  - Reset has priority over working.
  - A reset mid-run discards in-flight instructions.
- Deasserting working mid-run holds PC; instructions already in flight still complete.

Decomposition:
- Package processor_z_pkg holds:
  - opcode constants IRMOV, ADD, SUB, AND, XOR;
  - the alufun enum;
  - instruction field slice positions;
  - the NOP pipeline-register value.
- Three leaf sub-modules:
  - ram: 512x32, sync write, registered read.
  - regfile: 8x32, two read ports, two write ports (E and M), write-through, sync reset.
  - alu: combinational.
- The top module holds PC, the pipeline registers, forwarding muxes and the rdata mux.

Test Plan:
- Load, with 8 IRMOVs: 0x10F00080..0x10F70087 at addr 0..7, then reset, working=1 -> after all retire, r0..r7 = 0x80..0x87 and rdata with rID=3 gives 0x83.
- ALU ops: the same program plus 0x20010000, 0x21230000, 0x22450000, 0x23670000 -> r0=0x101, r2=0xFFFFFFFF, r4=0x84, r6=0x01, with r1/r3/r5/r7 unchanged.
- Dependency chain: append 0x21540000, 0x22760000, 0x20320000, 0x23100000 -> r5=0x1, r7=0x1, r3=0x82, r1=0x180.
- Back-to-back forwarding: 0x10F00005 then immediately 0x20000000 -> r0=0x0A. Also check that valE shows 0x0A when the ADD is in Execute.
- NOP and idle: zeroed RAM after the program -> registers stable. Assert working=0 mid-run -> PC holds and no further register changes after the in-flight instructions retire.
- Reset mid-run: registers read 0 at the next edge. rID=9 -> rdata=0. A wr pulse while working=1 leaves RAM unchanged.

Source files
------------

// File: rtl/processor_z_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : processor_z_pkg
//  Description : Shared opcodes, ALU function codes, instruction field
//                positions and the NOP pipeline-register value for the
//                Processor-Z datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package processor_z_pkg;

    localparam int XLEN      = 32;
    localparam int RIDX_W    = 4;
    localparam int REG_COUNT = 8;

    // {icode, ifun} encodings
    localparam logic [7:0] IRMOV = 8'h10;
    localparam logic [7:0] ADD   = 8'h20;
    localparam logic [7:0] SUB   = 8'h21;
    localparam logic [7:0] AND   = 8'h22;
    localparam logic [7:0] XOR   = 8'h23;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alufun_t;

    // Instruction field slice positions
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 24;
    localparam int RA_HI   = 23;
    localparam int RA_LO   = 20;
    localparam int RB_HI   = 19;
    localparam int RB_LO   = 16;
    localparam int VALC_HI = 15;
    localparam int VALC_LO = 0;

    localparam logic [XLEN-1:0] NOP_INSTR = '0;

    // Execute-stage pipeline register
    typedef struct packed {
        logic              we;
        logic [RIDX_W-1:0] dst;
        logic              is_alu;
        alufun_t           fun;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
    } ex_t;

    localparam ex_t EX_NOP = '{we: 1'b0, dst: '0, is_alu: 1'b0, fun: ALU_ADD, a: '0, b: '0};

    // Register indices 8..15 name no architectural register
    function automatic logic reg_ok(input logic [RIDX_W-1:0] idx);
        return idx < RIDX_W'(REG_COUNT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/processor_z_alu.sv
`default_nettype none
// ============================================================================
//  Module      : processor_z_alu
//  Description : Combinational 32-bit ALU: add, sub (A-B), and, xor.
//  Revision    : 1.0  initial release
// ============================================================================
module processor_z_alu
    import processor_z_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alufun_t           fun,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Modulo arithmetic, no flags
    always_comb begin
        y = '0;
        case (fun)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/processor_z_ram.sv
`default_nettype none
// ============================================================================
//  Module      : processor_z_ram
//  Description : Instruction RAM, synchronous write, registered read
//                (1-cycle latency). Not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module processor_z_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_q;

    // Host write port and registered fetch read port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        r_q <= r_mem[raddr];
    end

    assign rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/processor_z_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : processor_z_regfile
//  Description : 8x32 register file, two read ports, two write ports
//                (E = Execute, M = Write-back; E has priority), write-through.
//  Revision    : 1.0  initial release
// ============================================================================
module processor_z_regfile
    import processor_z_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RIDX_W-1:0]    ra_a,
    input  logic [RIDX_W-1:0]    ra_b,
    output logic [DATA_W-1:0]    rd_a,
    output logic [DATA_W-1:0]    rd_b,
    input  logic                 we_e,
    input  logic [RIDX_W-1:0]    wa_e,
    input  logic [DATA_W-1:0]    wd_e,
    input  logic                 we_m,
    input  logic [RIDX_W-1:0]    wa_m,
    input  logic [DATA_W-1:0]    wd_m,
    output logic [DATA_W-1:0]    regs [NREG]
);

    localparam int IDX_W = $clog2(NREG);

    logic [DATA_W-1:0] r_regs [NREG];

    // Storage update; the E write comes last so the younger instruction wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (we_m && (wa_m < RIDX_W'(NREG))) begin
                r_regs[wa_m[IDX_W-1:0]] <= wd_m;
            end
            if (we_e && (wa_e < RIDX_W'(NREG))) begin
                r_regs[wa_e[IDX_W-1:0]] <= wd_e;
            end
        end
    end

    // Port A read: out-of-range index reads 0, pending writes bypass storage
    always_comb begin
        rd_a = '0;
        if (ra_a < RIDX_W'(NREG)) begin
            rd_a = r_regs[ra_a[IDX_W-1:0]];
            if (we_m && (wa_m == ra_a)) rd_a = wd_m;
            if (we_e && (wa_e == ra_a)) rd_a = wd_e;
        end
    end

    // Port B read: same policy as port A
    always_comb begin
        rd_b = '0;
        if (ra_b < RIDX_W'(NREG)) begin
            rd_b = r_regs[ra_b[IDX_W-1:0]];
            if (we_m && (wa_m == ra_b)) rd_b = wd_m;
            if (we_e && (wa_e == ra_b)) rd_b = wd_e;
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_regs_out
            assign regs[gi] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/processor_z.sv
`default_nettype none
// ============================================================================
//  Module      : processor_z
//  Description : 4-stage in-order core (Fetch, Decode, Execute, Write-back)
//                running IRMOV/ADD/SUB/AND/XOR from a host-loaded RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module processor_z
    import processor_z_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              working,
    input  logic [3:0]        rID,
    output logic [DATA_W-1:0] valE,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = $clog2(NREG);

    // Fetch / Decode / Execute / Write-back state
    logic [ADDR_W-1:0]  r_pc;
    logic               r_f_valid;
    logic [DATA_W-1:0]  r_d_instr;
    ex_t                r_ex;
    logic               r_wb_we;
    logic [RIDX_W-1:0]  r_wb_dst;
    logic [DATA_W-1:0]  r_wb_val;

    logic [DATA_W-1:0]  w_ram_q;
    logic [DATA_W-1:0]  w_rf_a;
    logic [DATA_W-1:0]  w_rf_b;
    logic [DATA_W-1:0]  w_opa;
    logic [DATA_W-1:0]  w_opb;
    logic [DATA_W-1:0]  w_alu_y;
    logic [DATA_W-1:0]  w_regs [NREG];
    ex_t                w_dec;

    logic [7:0]         w_op;
    logic [RIDX_W-1:0]  w_ra;
    logic [RIDX_W-1:0]  w_rb;
    logic [15:0]        w_valc;

    assign w_op   = r_d_instr[OPC_HI:OPC_LO];
    assign w_ra   = r_d_instr[RA_HI:RA_LO];
    assign w_rb   = r_d_instr[RB_HI:RB_LO];
    assign w_valc = r_d_instr[VALC_HI:VALC_LO];

    // Host writes are only honoured in load mode
    processor_z_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clock),
        .we    (wr && !working),
        .waddr (addr),
        .wdata (wdata),
        .raddr (r_pc),
        .rdata (w_ram_q)
    );

    // Port E commits the Execute result; port M re-presents the last retired
    // result, and E's priority keeps a younger write to the same register.
    processor_z_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk  (clock),
        .rst  (reset),
        .ra_a (w_ra),
        .ra_b (w_rb),
        .rd_a (w_rf_a),
        .rd_b (w_rf_b),
        .we_e (r_ex.we),
        .wa_e (r_ex.dst),
        .wd_e (w_alu_y),
        .we_m (r_wb_we),
        .wa_m (r_wb_dst),
        .wd_m (r_wb_val),
        .regs (w_regs)
    );

    // IRMOV runs through the ALU as 0 + valC so one result path serves all ops
    processor_z_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .fun (r_ex.fun),
        .a   (r_ex.a),
        .b   (r_ex.b),
        .y   (w_alu_y)
    );

    // Operand selection: newest producer first (Execute, Write-back, regfile)
    always_comb begin
        w_opa = w_rf_a;
        w_opb = w_rf_b;
        if (r_wb_we && (r_wb_dst == w_ra)) w_opa = r_wb_val;
        if (r_wb_we && (r_wb_dst == w_rb)) w_opb = r_wb_val;
        if (r_ex.we && (r_ex.dst == w_ra)) w_opa = w_alu_y;
        if (r_ex.we && (r_ex.dst == w_rb)) w_opb = w_alu_y;
    end

    // Decode: unknown encodings become NOPs, out-of-range destinations never write
    always_comb begin
        w_dec = EX_NOP;
        case (w_op)
            IRMOV: begin
                w_dec.we         = reg_ok(w_rb);
                w_dec.dst        = w_rb;
                w_dec.fun        = ALU_ADD;
                w_dec.a          = '0;
                w_dec.b          = '0;
                w_dec.b[15:0]    = w_valc;
            end
            ADD, SUB, AND, XOR: begin
                w_dec.we     = reg_ok(w_ra);
                w_dec.dst    = w_ra;
                w_dec.is_alu = 1'b1;
                w_dec.fun    = alufun_t'(w_op[1:0]);
                w_dec.a      = w_opa;
                w_dec.b      = w_opb;
            end
            default: w_dec = EX_NOP;
        endcase
    end

    // Pipeline advance; reset flushes every stage and outranks working
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= '0;
            r_f_valid <= 1'b0;
            r_d_instr <= NOP_INSTR;
            r_ex      <= EX_NOP;
            r_wb_we   <= 1'b0;
            r_wb_dst  <= '0;
            r_wb_val  <= '0;
        end else begin
            if (working) begin
                r_pc <= r_pc + 1'b1;
            end
            r_f_valid <= working;
            r_d_instr <= r_f_valid ? w_ram_q : NOP_INSTR;
            r_ex      <= w_dec;
            r_wb_we   <= r_ex.we;
            r_wb_dst  <= r_ex.dst;
            r_wb_val  <= w_alu_y;
        end
    end

    assign valE = r_ex.is_alu ? w_alu_y : '0;

    // Host register view
    always_comb begin
        rdata = '0;
        if (rID < 4'(NREG)) begin
            rdata = w_regs[rID[IDX_W-1:0]];
        end
    end

    assign r0 = w_regs[0];
    assign r1 = w_regs[1];
    assign r2 = w_regs[2];
    assign r3 = w_regs[3];
    assign r4 = w_regs[4];
    assign r5 = w_regs[5];
    assign r6 = w_regs[6];
    assign r7 = w_regs[7];

endmodule
`default_nettype wire

// File: tb/tb_processor_z.sv
`default_nettype none
// ============================================================================
//  Module      : tb_processor_z
//  Description : Directed self-checking bench for processor_z.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_processor_z;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        wr      = 1'b0;
    logic        working = 1'b0;
    logic [8:0]  addr    = '0;
    logic [31:0] wdata   = '0;
    logic [3:0]  rID     = '0;
    logic [31:0] valE, rdata;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] regs_now [8];
    logic [31:0] exp_regs [8];
    logic [31:0] prog [$];

    processor_z dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .wr      (wr),
        .wdata   (wdata),
        .working (working),
        .rID     (rID),
        .valE    (valE),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .r4      (r4),
        .r5      (r5),
        .r6      (r6),
        .r7      (r7),
        .rdata   (rdata)
    );

    always #5 clock = ~clock;

    assign regs_now[0] = r0;
    assign regs_now[1] = r1;
    assign regs_now[2] = r2;
    assign regs_now[3] = r3;
    assign regs_now[4] = r4;
    assign regs_now[5] = r5;
    assign regs_now[6] = r6;
    assign regs_now[7] = r7;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_r%0d", tag, i), regs_now[i], exp_regs[i]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        addr  = 9'(a);
        wdata = d;
        wr    = 1'b1;
        tick(1);
        wr    = 1'b0;
    endtask

    // Writes prog[] from address 0 and zeros the rest of the first 32 words
    task automatic load_prog();
        for (int i = 0; i < 32; i++) begin
            host_write(i, (i < prog.size()) ? prog[i] : 32'h0);
        end
    endtask

    // Reset with working already high, then run n cycles and let the pipe drain
    task automatic run_prog(input int n);
        reset   = 1'b1;
        working = 1'b1;
        tick(1);
        reset   = 1'b0;
        tick(n);
        working = 1'b0;
        tick(6);
    endtask

    initial begin : main
        logic [31:0] seen;

        // Reset state
        tick(2);
        reset = 1'b0;
        tick(1);
        exp_regs = '{default: 32'h0};
        check_regs("reset");
        check("reset_valE", valE, 32'h0);
        check("reset_rdata", rdata, 32'h0);

        // Clear the whole RAM
        for (int i = 0; i < 512; i++) host_write(i, 32'h0);

        // 1: eight IRMOVs
        prog = '{32'h10F00080, 32'h10F10081, 32'h10F20082, 32'h10F30083,
                 32'h10F40084, 32'h10F50085, 32'h10F60086, 32'h10F70087};
        load_prog();
        run_prog(30);
        exp_regs = '{32'h80, 32'h81, 32'h82, 32'h83, 32'h84, 32'h85, 32'h86, 32'h87};
        check_regs("irmov");
        rID = 4'd3;
        tick(1);
        check("rdata_rid3", rdata, 32'h83);
        rID = 4'd9;
        tick(1);
        check("rdata_rid9", rdata, 32'h0);
        rID = 4'd7;
        tick(1);
        check("rdata_rid7", rdata, 32'h87);
        tick(20);
        check_regs("idle_stable");

        // 2: ALU ops, with a wr pulse while running that must be ignored
        prog.push_back(32'h20010000);
        prog.push_back(32'h21230000);
        prog.push_back(32'h22450000);
        prog.push_back(32'h23670000);
        load_prog();
        reset   = 1'b1;
        working = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        addr  = 9'd0;
        wdata = 32'h10F000FF;
        wr    = 1'b1;
        tick(1);
        wr    = 1'b0;
        tick(24);
        working = 1'b0;
        tick(6);
        exp_regs = '{32'h101, 32'h81, 32'hFFFFFFFF, 32'h83, 32'h84, 32'h85, 32'h01, 32'h87};
        check_regs("alu");

        // 3: dependency chain appended without touching address 0
        host_write(12, 32'h21540000);
        host_write(13, 32'h22760000);
        host_write(14, 32'h20320000);
        host_write(15, 32'h23100000);
        run_prog(30);
        exp_regs = '{32'h101, 32'h180, 32'hFFFFFFFF, 32'h82, 32'h84, 32'h1, 32'h1, 32'h1};
        check_regs("chain");

        // 4: mid-run reset discards everything in flight
        reset   = 1'b1;
        working = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(14);
        reset = 1'b1;
        @(posedge clock);
        #1;
        exp_regs = '{default: 32'h0};
        check_regs("midreset");
        check("midreset_valE", valE, 32'h0);
        @(negedge clock);
        reset   = 1'b0;
        working = 1'b0;
        tick(8);
        check_regs("midreset_flush");

        // 5: back-to-back forwarding and out-of-range register indices
        prog = '{32'h10F00005, 32'h20000000, 32'h10F90077, 32'h20090000};
        load_prog();
        reset   = 1'b1;
        working = 1'b1;
        tick(1);
        reset = 1'b0;
        seen  = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (valE == 32'h0000000A) seen = valE;
        end
        check("fwd_valE", seen, 32'h0000000A);
        tick(10);
        working = 1'b0;
        tick(6);
        exp_regs = '{32'h0A, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        check_regs("fwd");

        // 6: working drop holds PC; in-flight instructions still retire
        prog.delete();
        for (int k = 0; k < 8; k++) prog.push_back(32'h10F00010 + (k << 16) + k);
        load_prog();
        reset   = 1'b1;
        working = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        working = 1'b0;
        tick(30);
        exp_regs = '{32'h10, 32'h11, 32'h12, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        check_regs("pause");
        working = 1'b1;
        tick(12);
        working = 1'b0;
        tick(6);
        exp_regs = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
        check_regs("resume");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
